// File: rtl/sbox_codec_pkg.sv
// Shared constants, share bundle type and LFSR step for the S-box share codec.
package sbox_codec_pkg;

    localparam int unsigned LFSR_W = 160;
    localparam int unsigned TAP_A  = 160;
    localparam int unsigned TAP_B  = 159;
    localparam int unsigned TAP_C  = 158;
    localparam int unsigned TAP_D  = 157;
    localparam int unsigned R_W    = 144;
    localparam int unsigned SH_W   = 8;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1);

    typedef struct packed {
        logic [SH_W-1:0] sh3;
        logic [SH_W-1:0] sh2;
        logic [SH_W-1:0] sh1;
    } shares_t;

    // Fibonacci step: feedback from the four top taps enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
        logic fb;
        fb = r[TAP_A-1] ^ r[TAP_B-1] ^ r[TAP_C-1] ^ r[TAP_D-1];
        return {r[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/sbox_codec_lfsr.sv
// Free-running 160-bit mask/randomness generator.
module sbox_codec_lfsr
    import sbox_codec_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_ni,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/sbox_share_codec.sv
// Masks bytes into three shares for the S-box pair, recombines the returned
// shares after the fixed pipeline latency and buffers results in a credit-guarded FIFO.
module sbox_share_codec
    import sbox_codec_pkg::*;
#(
    parameter int unsigned       LAT   = 2,
    parameter int unsigned       DEPTH = 8,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SH_W-1:0] in_data,
    output logic [SH_W-1:0] sh1_o,
    output logic [SH_W-1:0] sh2_o,
    output logic [SH_W-1:0] sh3_o,
    output logic [R_W-1:0]  r_o,
    input  logic [SH_W-1:0] sh1_i,
    input  logic [SH_W-1:0] sh2_i,
    input  logic [SH_W-1:0] sh3_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SH_W-1:0] out_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + LAT + 2);

    logic [LFSR_W-1:0] r_q;
    logic [SH_W-1:0]   m1;
    logic [SH_W-1:0]   m2;
    shares_t           sh_q;
    logic [LAT:0]      vp_q;
    logic [SH_W-1:0]   mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     inflight;
    logic              accept;
    logic              push;
    logic              pop;

    sbox_codec_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_ni (rst_ni),
        .state  (r_q)
    );

    assign m1  = r_q[SH_W-1:0];
    assign m2  = r_q[2*SH_W-1:SH_W];
    assign r_o = r_q[LFSR_W-1:2*SH_W];

    assign accept = in_valid && in_ready;
    assign push   = vp_q[LAT];
    assign pop    = out_valid && out_ready;

    // Idle cycles still present a masked 0x00 so the S-box never sees plain data.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q.sh1 <= m1;
            sh_q.sh2 <= m2;
            sh_q.sh3 <= (accept ? in_data : SH_W'(0)) ^ m1 ^ m2;
        end
    end

    assign sh1_o = sh_q.sh1;
    assign sh2_o = sh_q.sh2;
    assign sh3_o = sh_q.sh3;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            vp_q <= '0;
        end else begin
            vp_q <= {vp_q[LAT-1:0], accept};
        end
    end

    // Every in-flight byte holds a reserved FIFO slot, so a push can never overflow.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i <= LAT; i++) begin
            inflight = inflight + CW'(vp_q[i]);
        end
    end

    assign in_ready = rst_ni && ((inflight + cnt_q) < CW'(DEPTH));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sh1_i ^ sh2_i ^ sh3_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sbox_share_codec.sv
// Directed bench for sbox_share_codec with a behavioural SKINNY 4-bit S-box pair attached.
`timescale 1ns/1ps
module tb_sbox_share_codec;
    import sbox_codec_pkg::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 8;
    localparam logic [LFSR_W-1:0] SEED = DEFAULT_SEED;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic [7:0]      sh1_o, sh2_o, sh3_o;
    logic [R_W-1:0]  r_o;
    logic [7:0]      sh1_i, sh2_i, sh3_i;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int n_accs   = 0;

    sbox_share_codec #(.LAT(LAT), .DEPTH(DEPTH), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sh1_o     (sh1_o),
        .sh2_o     (sh2_o),
        .sh3_o     (sh3_o),
        .r_o       (r_o),
        .sh1_i     (sh1_i),
        .sh2_i     (sh2_i),
        .sh3_i     (sh3_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] s4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
            4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
            4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
            4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
        endcase
    endfunction

    function automatic logic [7:0] s8(input logic [7:0] x);
        return {s4(x[7:4]), s4(x[3:0])};
    endfunction

    // S-box pair model: LAT-stage pipeline that re-shares its output with masks from r_o.
    logic [7:0] p1 [LAT];
    logic [7:0] p2 [LAT];
    logic [7:0] p3 [LAT];
    always @(posedge clk) begin
        logic [7:0] y;
        y = s8(sh1_o ^ sh2_o ^ sh3_o);
        p1[0] <= r_o[7:0];
        p2[0] <= r_o[15:8];
        p3[0] <= y ^ r_o[7:0] ^ r_o[15:8];
        for (int i = 1; i < LAT; i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
            p3[i] <= p3[i-1];
        end
    end
    assign sh1_i = p1[LAT-1];
    assign sh2_i = p2[LAT-1];
    assign sh3_i = p3[LAT-1];

    logic [7:0]        exp_x;
    logic [7:0]        exp_x_nxt = 8'h00;
    logic [LFSR_W-1:0] exp_r;
    logic [7:0]        exp_q [$];

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_x <= 8'h00;
            exp_r <= SEED;
        end else begin
            exp_x <= exp_x_nxt;
            exp_r <= lfsr_next(exp_r);
        end
    end

    // Per-cycle monitor: share recombination, randomness, and output scoreboard.
    always @(negedge clk) begin
        check("share_xor", sh1_o ^ sh2_o ^ sh3_o, exp_x);
        check("r_o", r_o, exp_r[LFSR_W-1:16]);
        if (out_valid && out_ready) begin
            n_pops++;
            if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
            else check("out_data", out_data, exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            n_accs++;
            exp_q.push_back(s8(in_data));
            exp_x_nxt = in_data;
        end else begin
            exp_x_nxt = 8'h00;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [7:0] d);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        check("send_accept", done, 1);
    endtask

    task automatic latency_test(input logic [7:0] d, input logic [7:0] y, input string tag);
        send_one(d);
        repeat (LAT) tick();
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, y);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int pops0, accs0, stale;
        rst_ni    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sh1", sh1_o, 0);
        check("rst_sh2", sh2_o, 0);
        check("rst_sh3", sh3_o, 0);
        check("rst_r_o", r_o, 144'h0);

        // Seed 1 walks left: after 20 shifts bit 20 is set, i.e. r_o bit 4.
        rst_ni = 1'b1;
        repeat (20) tick();
        check("lfsr_walk", r_o, 144'h10);

        out_ready = 1'b1;
        latency_test(8'h00, 8'hCC, "lat00");
        repeat (3) tick();
        latency_test(8'h10, 8'h6C, "lat10");
        repeat (3) tick();

        fork
            begin
                in_valid = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    in_data = 8'(i);
                    @(negedge clk);
                    check("b2b_ready", in_ready, 1);
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                int run, best, total;
                run = 0; best = 0; total = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (out_valid) begin
                        run++;
                        total++;
                        if (run > best) best = run;
                    end else begin
                        run = 0;
                    end
                end
                check("b2b_run", best, 16);
                check("b2b_total", total, 16);
            end
        join
        repeat (4) tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        accs0 = n_accs;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(8'h20 + (n_accs - accs0));
            @(negedge clk);
            tick();
        end
        check("bp_accepted", n_accs - accs0, 8);
        check("bp_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);

        // Later pulses line up with the landing push of the byte the previous pulse admitted.
        accs0 = n_accs;
        pops0 = n_pops;
        for (int k = 0; k < 3; k++) begin
            in_data   = 8'(8'h30 + k);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            repeat (LAT + 1) tick();
        end
        check("pulse_accepts", n_accs - accs0, 3);
        check("pulse_pops", n_pops - pops0, 3);
        check("pulse_full", in_ready, 0);
        in_valid = 1'b0;
        repeat (2) tick();
        check("pulse_valid", out_valid, 1);

        pops0 = n_pops;
        out_ready = 1'b1;
        repeat (12) tick();
        check("drain_pops", n_pops - pops0, 8);
        check("drain_ready", in_ready, 1);
        check("drain_empty", exp_q.size(), 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h40 + i);
            @(negedge clk);
            check("mid_ready", in_ready, 1);
            tick();
        end
        check("mid_buffered", out_valid, 1);
        rst_ni   = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_data", out_data, 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            tick();
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);
        latency_test(8'h35, 8'h0A, "post_rst");
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
